// File: rtl/logic_gate_array_pipe.sv
// NUM_IN-operand bitwise gate array with a registered valid/ready output stage
// and a 2-entry skid buffer. Optional stats ports are enabled by LOGIC_GATE_STATS_EN.
module logic_gate_array_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [2:0]              out_op
`ifdef LOGIC_GATE_STATS_EN
  ,
  output logic [15:0]             xfer_count,
  output logic                    busy_stall
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_BUF  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_result;
  logic             w_in_xfer;
  logic             w_out_xfer;

  logic [WIDTH-1:0] r_m_data;
  logic [2:0]       r_m_op;
  logic             r_m_full;
  logic [WIDTH-1:0] r_s_data;
  logic [2:0]       r_s_op;
  logic             r_s_full;

  always_comb begin
    w_and    = '1;
    w_or     = '0;
    w_xor    = '0;
    w_result = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      w_and = w_and & in_data[k*WIDTH +: WIDTH];
      w_or  = w_or  | in_data[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ in_data[k*WIDTH +: WIDTH];
    end
    case (op_e'(in_op))
      OP_AND:  w_result = w_and;
      OP_OR:   w_result = w_or;
      OP_XOR:  w_result = w_xor;
      OP_NAND: w_result = ~w_and;
      OP_NOR:  w_result = ~w_or;
      OP_XNOR: w_result = ~w_xor;
      OP_BUF:  w_result = in_data[WIDTH-1:0];
      OP_NOT:  w_result = ~in_data[WIDTH-1:0];
      default: w_result = '0;
    endcase
  end

  // in_ready depends only on skid occupancy and reset, never on out_ready
  assign in_ready   = ~r_s_full & ~rst;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_m_full & out_ready;

  assign out_valid = r_m_full;
  assign out_data  = r_m_data;
  assign out_op    = r_m_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_data <= '0;
      r_m_op   <= '0;
      r_m_full <= 1'b0;
      r_s_data <= '0;
      r_s_op   <= '0;
      r_s_full <= 1'b0;
    end else if (!r_m_full) begin
      if (w_in_xfer) begin
        r_m_data <= w_result;
        r_m_op   <= in_op;
        r_m_full <= 1'b1;
      end
    end else if (w_out_xfer) begin
      if (r_s_full) begin
        r_m_data <= r_s_data;
        r_m_op   <= r_s_op;
        r_s_full <= 1'b0;
      end else if (w_in_xfer) begin
        r_m_data <= w_result;
        r_m_op   <= in_op;
      end else begin
        r_m_full <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_s_data <= w_result;
      r_s_op   <= in_op;
      r_s_full <= 1'b1;
    end
  end

`ifdef LOGIC_GATE_STATS_EN
  logic [15:0] r_xfer_count;
  logic        r_busy_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_count <= '0;
      r_busy_stall <= 1'b0;
    end else begin
      if (w_out_xfer && (r_xfer_count != '1))
        r_xfer_count <= r_xfer_count + 16'd1;
      r_busy_stall <= r_m_full & ~out_ready;
    end
  end

  assign xfer_count = r_xfer_count;
  assign busy_stall = r_busy_stall;
`endif

endmodule

// File: tb/tb_logic_gate_array_pipe.sv
// Scoreboard bench for logic_gate_array_pipe: directed vectors with hand-computed
// results; a negedge monitor pops and compares each output transfer.
`timescale 1ns/1ps
module tb_logic_gate_array_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_op;
`ifdef LOGIC_GATE_STATS_EN
  logic [15:0] xfer_count;
  logic        busy_stall;
`endif

  logic_gate_array_pipe #(.WIDTH(8), .NUM_IN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_op(out_op)
`ifdef LOGIC_GATE_STATS_EN
    , .xfer_count(xfer_count), .busy_stall(busy_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [10:0] sb[$];

  // operand 0 in the low byte
  logic [31:0] opnd [3] = '{32'hFFAACCF0, 32'h0055330F, 32'h08040201};
  // rows: operand set; columns: AND OR XOR NAND NOR XNOR BUF NOT
  logic [7:0] exp_tab [3][8] = '{
    '{8'h80, 8'hFF, 8'h69, 8'h7F, 8'h00, 8'h96, 8'hF0, 8'h0F},
    '{8'h00, 8'h7F, 8'h69, 8'hFF, 8'h80, 8'h96, 8'h0F, 8'hF0},
    '{8'h00, 8'h0F, 8'h0F, 8'hFF, 8'hF0, 8'hF0, 8'h01, 8'hFE}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none", {out_op, out_data});
      end else begin
        chk("out_op_data", {21'd0, out_op, out_data}, {21'd0, sb.pop_front()});
      end
    end
  end

  task automatic send(input int s, input logic [2:0] op, output bit stalled);
    stalled  = 1'b0;
    in_valid = 1'b1;
    in_data  = opnd[s];
    in_op    = op;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({op, exp_tab[s][op]});
        @(posedge clk); #1;
        return;
      end
      stalled = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    bit st;
    int base;
    int stalls;

    rst = 1'b1; in_valid = 1'b1; in_data = opnd[0]; in_op = 3'd0; out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_op_data", {out_op, out_data}, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("post_rst_out_valid", out_valid, 0);

    for (int op = 0; op < 8; op++) begin
      send(0, 3'(op), st);
      in_valid = 1'b0;
      chk("latency_valid", out_valid, 1);
      @(posedge clk); #1;
      chk("latency_empty", out_valid, 0);
    end

    base = n_out;
    out_ready = 1'b0;
    send(0, 3'd0, st);
    send(0, 3'd1, st);
    in_valid = 1'b0;
    chk("bp_in_ready", in_ready, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_stable", {out_valid, out_op, out_data}, {1'b1, 3'd0, 8'h80});
    end
    out_ready = 1'b1;
    send(0, 3'd2, st);
    send(0, 3'd3, st);
    in_valid = 1'b0;
    drain();
    chk("bp_count", n_out - base, 4);

    base = n_out;
    stalls = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(i % 3, 3'(i % 8), st);
      if (st) stalls++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("tp_count", n_out - base, 20);
    chk("tp_stalls", stalls, 0);

    base = n_out;
    out_ready = 1'b0;
    send(2, 3'd6, st);
    send(2, 3'd7, st);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 chk("midrst_release_ready", in_ready, 1);
    send(2, 3'd1, st);
    in_valid = 1'b0;
    drain();
    chk("midrst_count", n_out - base, 1);

`ifdef LOGIC_GATE_STATS_EN
    chk("stats_count_after_rst", xfer_count, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) send(i % 3, 3'(i % 8), st);
    in_valid = 1'b0;
    drain();
    chk("stats_saturate", xfer_count, 16'hFFFF);
    out_ready = 1'b0;
    send(0, 3'd0, st);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stats_busy_stall", busy_stall, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stats_busy_clear", busy_stall, 0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
